// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data memory: pipeline (port 0) is
// preferred, port 1 gets starvation relief after MAX_WAIT losses and may lock bursts.
module dmem_arbiter #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 64,
   parameter int MAX_WAIT  = 4,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0,
   input  logic              we0,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [DATA_W-1:0] wdata0,
   output logic              gnt0,
   output logic              stall0,
   output logic              rvalid0,
   output logic [DATA_W-1:0] rdata0,
   input  logic              req1,
   input  logic              we1,
   input  logic              lock1,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt1,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
   localparam int BURST_W = $clog2(MAX_BURST + 1);

   typedef struct packed {
      logic              req;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } port_req_t;

   port_req_t [1:0]          preq;
   logic [1:0]               gnt;
   logic [1:0]               rvalid;
   logic [1:0][DATA_W-1:0]   rdata;
   logic [WAIT_W-1:0]        wait_cnt;
   logic [BURST_W-1:0]       burst_cnt;
   logic [BURST_W-1:0]       burst_next;
   logic                     burst_active;
   logic                     starved;

   // Requests are masked while in reset so no access can reach the memory.
   assign preq[0] = {req0 & rst_n, we0, addr0, wdata0};
   assign preq[1] = {req1 & rst_n, we1, addr1, wdata1};

   assign starved    = (wait_cnt == WAIT_W'(MAX_WAIT));
   assign burst_next = burst_cnt + 1'b1;

   always_comb begin
      gnt = 2'b00;
      if (burst_active && preq[1].req)                gnt = 2'b10;
      else if (preq[0].req && preq[1].req && starved) gnt = 2'b10;
      else if (preq[0].req)                           gnt = 2'b01;
      else if (preq[1].req)                           gnt = 2'b10;
   end

   // Idle cycles park the memory bus on port 0.
   assign mem_addr  = gnt[1] ? preq[1].addr  : preq[0].addr;
   assign mem_wdata = gnt[1] ? preq[1].wdata : preq[0].wdata;
   assign mem_we    = (gnt[0] & preq[0].we) | (gnt[1] & preq[1].we);

   assign gnt0    = gnt[0];
   assign gnt1    = gnt[1];
   assign stall0  = req0 & ~gnt[0];
   assign rvalid0 = rvalid[0];
   assign rvalid1 = rvalid[1];
   assign rdata0  = rdata[0];
   assign rdata1  = rdata[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= '0;
         rdata  <= '0;
      end else begin
         for (int p = 0; p < 2; p++) begin
            rvalid[p] <= gnt[p] & ~preq[p].we;
            if (gnt[p] && !preq[p].we) rdata[p] <= mem_rdata;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt     <= '0;
         burst_cnt    <= '0;
         burst_active <= 1'b0;
      end else begin
         if (!preq[1].req || gnt[1]) wait_cnt <= '0;
         else if (!starved)          wait_cnt <= wait_cnt + 1'b1;

         // The grant that reaches MAX_BURST ends the burst so port 0 gets the next slot.
         if (!preq[1].req || !lock1) begin
            burst_cnt    <= '0;
            burst_active <= 1'b0;
         end else if (gnt[1]) begin
            if (burst_next < BURST_W'(MAX_BURST)) begin
               burst_cnt    <= burst_next;
               burst_active <= 1'b1;
            end else begin
               burst_cnt    <= '0;
               burst_active <= 1'b0;
            end
         end
      end
   end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vectors, a behavioural model checked every
// negedge, and literal expectations for the key scenarios.
module tb_dmem_arbiter;
   localparam int ADDR_W    = 8;
   localparam int DATA_W    = 64;
   localparam int MAX_WAIT  = 4;
   localparam int MAX_BURST = 8;

   logic              clk    = 1'b0;
   logic              rst_n  = 1'b1;
   logic              req0   = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
   logic [ADDR_W-1:0] addr0  = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic              gnt0, stall0, rvalid0, gnt1, rvalid1, mem_we;
   logic [DATA_W-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
   logic [ADDR_W-1:0] mem_addr;

   int n_cmp = 0;
   int n_err = 0;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .gnt0(gnt0), .stall0(stall0), .rvalid0(rvalid0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
      .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Power-up contents of any location never written.
   function automatic logic [63:0] pat(input logic [7:0] a);
      return {48'hC0FF_EE00_0000, a, ~a};
   endfunction

   // Data memory the arbiter drives.
   bit [63:0] mem      [256];
   bit        mem_seen [256];
   always @(posedge clk) begin
      if (mem_we) begin
         mem[mem_addr]      <= mem_wdata;
         mem_seen[mem_addr] <= 1'b1;
      end
   end
   always_comb mem_rdata = mem_seen[mem_addr] ? mem[mem_addr] : pat(mem_addr);

   task automatic chkw(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic chkb(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: memory contents, port 1 loss streak and locked-grant count.
   bit [63:0]   ref_mem  [256];
   bit          ref_seen [256];
   int          m_lose = 0;
   int          m_bgr  = 0;
   bit          m_rv0  = 1'b0, m_rv1 = 1'b0;
   logic [63:0] m_rd0  = '0, m_rd1 = '0;

   function automatic logic [63:0] ref_rd(input logic [7:0] a);
      return ref_seen[a] ? ref_mem[a] : pat(a);
   endfunction

   always @(negedge clk) begin
      bit          e0, e1, ewe;
      logic [7:0]  ea;
      logic [63:0] ed;
      e0 = 1'b0;
      e1 = 1'b0;
      if (!rst_n) begin
         m_lose = 0; m_bgr = 0;
         m_rv0 = 1'b0; m_rv1 = 1'b0;
         m_rd0 = '0; m_rd1 = '0;
      end else if (m_bgr > 0 && req1)                  e1 = 1'b1;
      else if (req0 && req1 && m_lose >= MAX_WAIT)      e1 = 1'b1;
      else if (req0)                                    e0 = 1'b1;
      else if (req1)                                    e1 = 1'b1;
      ea  = e1 ? addr1 : addr0;
      ed  = e1 ? wdata1 : wdata0;
      ewe = (e0 && we0) || (e1 && we1);

      chkb("gnt0", gnt0, e0);
      chkb("gnt1", gnt1, e1);
      chkb("stall0", stall0, req0 && !e0);
      chkb("mem_we", mem_we, ewe);
      chkw("mem_addr", 64'(mem_addr), 64'(ea));
      chkw("mem_wdata", mem_wdata, ed);
      chkb("rvalid0", rvalid0, m_rv0);
      chkb("rvalid1", rvalid1, m_rv1);
      chkw("rdata0", rdata0, m_rd0);
      chkw("rdata1", rdata1, m_rd1);

      if (rst_n) begin
         m_rv0 = e0 && !we0;
         m_rv1 = e1 && !we1;
         if (m_rv0) m_rd0 = ref_rd(addr0);
         if (m_rv1) m_rd1 = ref_rd(addr1);
         if (ewe) begin
            ref_mem[ea]  = ed;
            ref_seen[ea] = 1'b1;
         end
         if (req1 && !e1) m_lose = (m_lose < MAX_WAIT) ? m_lose + 1 : MAX_WAIT;
         else             m_lose = 0;
         if (!req1 || !lock1) m_bgr = 0;
         else if (e1)         m_bgr = (m_bgr + 1 == MAX_BURST) ? 0 : m_bgr + 1;
      end
   end

   task automatic drive(input logic r0, input logic w0, input logic [7:0] a0, input logic [63:0] d0,
                        input logic r1, input logic w1, input logic l1, input logic [7:0] a1,
                        input logic [63:0] d1);
      req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
      req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] a1v;
   logic       g;

   initial begin
      // Reset with both ports requesting.
      rst_n = 1'b0;
      drive(1'b1, 1'b0, 8'd0, '0, 1'b1, 1'b0, 1'b0, 8'd0, '0);
      tick();
      tick();
      #1;
      chkb("rst_gnt0", gnt0, 1'b0);
      chkb("rst_gnt1", gnt1, 1'b0);
      chkb("rst_mem_we", mem_we, 1'b0);
      chkb("rst_rvalid0", rvalid0, 1'b0);
      chkb("rst_rvalid1", rvalid1, 1'b0);
      rst_n = 1'b1;
      #1;
      chkb("first_gnt0", gnt0, 1'b1);

      // Both requesting, no lock: port 1 wins every 5th cycle.
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 8'(i), '0, 1'b1, 1'b0, 1'b0, 8'(100 + i), '0);
         #1;
         chkb("starve_gnt1", gnt1, (i % 5) == 4);
         chkb("starve_stall0", stall0, (i % 5) == 4);
         tick();
      end

      // Port 0 alone: write then read back.
      drive(1'b1, 1'b1, 8'd1, 64'h9, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      #1;
      chkb("p0_wr_gnt0", gnt0, 1'b1);
      chkb("p0_wr_stall0", stall0, 1'b0);
      chkb("p0_wr_we", mem_we, 1'b1);
      tick();
      drive(1'b1, 1'b0, 8'd1, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      #1;
      chkb("p0_rd_gnt0", gnt0, 1'b1);
      chkb("p0_rd_stall0", stall0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      #1;
      chkb("p0_rvalid", rvalid0, 1'b1);
      chkw("p0_rdata", rdata0, 64'h9);
      tick();
      #1;
      chkb("p0_rvalid_drop", rvalid0, 1'b0);

      // Locked port 1 burst against a continuously requesting port 0.
      a1v = 8'd0;
      for (int i = 0; i < 18; i++) begin
         drive(1'b1, 1'b0, 8'd20, '0, 1'b1, 1'b0, 1'b1, a1v, '0);
         #1;
         chkb("burst_gnt1", gnt1, (i >= 4 && i <= 11) || i >= 16);
         g = gnt1;
         tick();
         if (g) a1v = a1v + 8'd1;
      end
      #1;
      chkb("burst_rvalid1", rvalid1, 1'b1);
      chkw("burst_rdata1", rdata1, pat(8'd9));

      // Reset arrives before the edge that would complete a port 1 read.
      drive(1'b0, 1'b0, 8'd0, '0, 1'b1, 1'b0, 1'b0, 8'd3, '0);
      #1;
      chkb("rst_rd_gnt1", gnt1, 1'b1);
      rst_n = 1'b0;
      tick();
      chkb("rst_rd_rvalid1", rvalid1, 1'b0);
      chkw("rst_rd_rdata1", rdata1, 64'h0);
      drive(1'b0, 1'b0, 8'd0, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      rst_n = 1'b1;
      tick();

      // Port 1 writes, port 0 reads it back in the following cycle.
      drive(1'b0, 1'b0, 8'd0, '0, 1'b1, 1'b1, 1'b0, 8'd50, 64'hDEAD_BEEF_0000_0050);
      #1;
      chkb("p1_wr_gnt1", gnt1, 1'b1);
      chkb("p1_wr_we", mem_we, 1'b1);
      tick();
      drive(1'b1, 1'b0, 8'd50, '0, 1'b0, 1'b0, 1'b0, 8'd0, '0);
      tick();
      // Idle, with write enables and data wiggling but no request.
      drive(1'b0, 1'b1, 8'd7, 64'hFFFF, 1'b0, 1'b1, 1'b0, 8'd9, 64'hEEEE);
      #1;
      chkb("p1wr_p0rd_rvalid", rvalid0, 1'b1);
      chkw("p1wr_p0rd_rdata", rdata0, 64'hDEAD_BEEF_0000_0050);
      tick();
      for (int i = 0; i < 3; i++) begin
         #1;
         chkb("idle_we", mem_we, 1'b0);
         chkb("idle_rvalid0", rvalid0, 1'b0);
         chkb("idle_rvalid1", rvalid1, 1'b0);
         chkw("idle_rdata0", rdata0, 64'hDEAD_BEEF_0000_0050);
         chkw("idle_rdata1", rdata1, 64'h0);
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 256 x 64-bit data memory between two requesters:
  - Port 0: pipeline memory-access stage.
  - Port 1: auxiliary requester, such as a memory loader or debug port.
- Sits between both requesters and the data memory instance.
- Decides one owner per cycle, drives the memory address, write data and write enable, and returns registered read data.
- Asserts a stall to the pipeline when port 0 loses arbitration.

Parameters:
ADDR_W, 8, memory address width (256 entries)
DATA_W, 64, memory data width
MAX_WAIT, 4, consecutive losing cycles after which port 1 wins over port 0
MAX_BURST, 8, maximum consecutive grants port 1 may hold under lock

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
req0  input  1  port 0 access request
we0  input  1  port 0 write (1) / read (0)
addr0  input  ADDR_W  port 0 address
wdata0  input  DATA_W  port 0 write data
gnt0  output  1  port 0 granted this cycle
stall0  output  1  req0 && !gnt0, to pipeline
rvalid0  output  1  port 0 read data valid
rdata0  output  DATA_W  port 0 read data
req1  input  1  port 1 access request
we1  input  1  port 1 write / read
lock1  input  1  port 1 requests to keep ownership (burst)
addr1  input  ADDR_W  port 1 address
wdata1  input  DATA_W  port 1 write data
gnt1  output  1  port 1 granted this cycle
rvalid1  output  1  port 1 read data valid
rdata1  output  DATA_W  port 1 read data
mem_addr  output  ADDR_W  to data memory address
mem_wdata  output  DATA_W  to data memory write data
mem_we  output  1  to data memory write enable
mem_rdata  input  DATA_W  combinational read data from memory

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst_n is asynchronous and active-low.
  - On reset, all of the following clear to 0: rvalid0/1, rdata0/1, wait_cnt, burst_cnt, burst_active.
  - gnt0/1, stall0 and mem_we are combinational, so they are 0 whenever there is no request.
- Grant selection (combinational from req*, lock1 and state), evaluated in priority order; at most one grant per cycle:
  1. burst_active && req1 → gnt1.
  2. req0 && req1 && wait_cnt == MAX_WAIT → gnt1.
  3. req0 → gnt0.
  4. req1 → gnt1.
  5. Otherwise no grant.
- Memory drive:
  - mem_addr/mem_wdata come from the granted port.
  - With no grant, they come from port 0 and mem_we = 0.
  - mem_we = granted port's we.
- Write completion: the write commits at the rising edge of the granted cycle.
- Read response:
  - At the edge ending a granted read, rdataX <= mem_rdata and rvalidX <= 1.
  - rvalidX is 1 for exactly one cycle per granted read and 0 after writes or idle.
  - rdataX holds its last value otherwise.
  - Read latency is 1 cycle from grant.
- Starvation counter wait_cnt, width clog2(MAX_WAIT+1):
  - Increments when req1 && !gnt1, saturating at MAX_WAIT.
  - Clears when gnt1 or !req1.
- Burst logic:
  - burst_active sets at an edge where gnt1 && lock1 && burst_cnt+1 < MAX_BURST.
  - burst_cnt increments on each gnt1 while lock1.
  - burst_active and burst_cnt clear when lock1 == 0, req1 == 0, or MAX_BURST grants have been issued.
  - Port 1 therefore receives at most MAX_BURST consecutive grants; the next cycle arbitrates normally with port 0 preferred.
- Simultaneous write/read to the same address by different ports in different cycles: ordering follows grant order; the arbiter does no forwarding.
- stall0 = req0 && !gnt0, purely combinational.
- Request signals must remain stable while stalled; the arbiter does not latch them.
- Reset mid-access: the in-flight read response is discarded (rvalid cleared), and no write is issued while rst_n is low.

Test Plan:
- Reset with req0 = req1 = 1 held → gnt0 = gnt1 = 0, mem_we = 0, rvalid0/1 = 0; after release, the first cycle grants port 0.
- Port 0 only: write 64'h9 to addr 1, then read addr 1 → gnt0 = 1 both cycles, rvalid0 = 1 one cycle after the read, rdata0 = 64'h9, stall0 = 0.
- Both requesting continuously, lock1 = 0, MAX_WAIT = 4 → port 0 is granted 4 cycles, port 1 on the 5th (stall0 = 1 that cycle), then the pattern repeats.
- Port 1 burst: lock1 = 1, req1 = 1, req0 = 1, reads of addr 0..9 → gnt1 for 8 consecutive cycles, then gnt0 next cycle, then port 1 after starvation.
- Port 1 read of addr 3 granted, rst_n pulsed low before the next edge → rvalid1 stays 0, rdata1 = 0.
- Idle (no req) for 3 cycles → mem_we = 0, rvalid0/1 = 0, rdata values unchanged.
